// File: rtl/riscv_crypto_aes32_round_seq.sv
// AES round engine: walks a single-cycle saes32 datapath through 16 byte-steps per 128-bit round.
// Define RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN to build the inverse datapath and honour req_dec.
module riscv_crypto_aes32_round_seq (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic         req_last,
  input  logic [127:0] req_state,
  input  logic [127:0] req_rkey,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state
);

`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
  localparam bit SaesDecEn = 1'b1;
`else
  localparam bit SaesDecEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction
`endif

  state_e         st_q, st_d;
  logic [3:0]     step_q, step_d;
  logic [31:0]    acc_q, acc_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   rkey_q, rkey_d;
  logic [127:0]   out_q, out_d;
  logic           dec_q, dec_d;
  logic           last_q, last_d;
  logic           accept;

  logic [1:0]     col, bs, src;
  logic           fu_valid;
  logic [31:0]    fu_rs1, fu_rs2, fu_rd;
  logic [1:0]     fu_bs;
  logic [3:0]     fu_op;
  logic [7:0]     fu_sel, fu_sub_f;
  logic [31:0]    fu_mix, fu_rot;
`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
  logic [7:0]     fu_sub_i;
`else
  logic           unused_fu_op;
  assign unused_fu_op = ^fu_op[3:2];
`endif

  assign req_ready = (st_q == StIdle) || ((st_q == StDone) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (st_q == StDone);
  assign rsp_state = out_q;

  // Forward rounds read along ShiftRows diagonals, inverse rounds along InvShiftRows ones.
  assign col      = step_q[3:2];
  assign bs       = step_q[1:0];
  assign src      = dec_q ? (col - bs) : (col + bs);
  assign fu_valid = (st_q == StRun);
  assign fu_bs    = bs;
  assign fu_rs2   = state_q[{src, 5'b0} +: 32];
  assign fu_rs1   = (bs == 2'd0) ? rkey_q[{col, 5'b0} +: 32] : acc_q;

  always_comb begin
    fu_op = 4'b0001;
    case ({dec_q, last_q})
      2'b00:   fu_op = 4'b0001;  // encsm
      2'b01:   fu_op = 4'b0010;  // encs
      2'b10:   fu_op = 4'b0100;  // decsm
      default: fu_op = 4'b1000;  // decs
    endcase
  end

  always_comb begin
    fu_sel = fu_rs2[7:0];
    unique case (fu_bs)
      2'd0: fu_sel = fu_rs2[7:0];
      2'd1: fu_sel = fu_rs2[15:8];
      2'd2: fu_sel = fu_rs2[23:16];
      2'd3: fu_sel = fu_rs2[31:24];
    endcase
    fu_sub_f = sbox_fwd(fu_sel);
`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
    fu_sub_i = sbox_inv(fu_sel);
`endif
    fu_mix = '0;
    unique case (1'b1)
      fu_op[0]: fu_mix = {gf_mul(fu_sub_f, 8'h03), fu_sub_f, fu_sub_f, gf_mul(fu_sub_f, 8'h02)};
      fu_op[1]: fu_mix = {24'h0, fu_sub_f};
`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
      fu_op[2]: fu_mix = {gf_mul(fu_sub_i, 8'h0b), gf_mul(fu_sub_i, 8'h0d),
                          gf_mul(fu_sub_i, 8'h09), gf_mul(fu_sub_i, 8'h0e)};
      fu_op[3]: fu_mix = {24'h0, fu_sub_i};
`endif
      default:  fu_mix = '0;
    endcase
    fu_rot = fu_mix;
    unique case (fu_bs)
      2'd0: fu_rot = fu_mix;
      2'd1: fu_rot = {fu_mix[23:0], fu_mix[31:24]};
      2'd2: fu_rot = {fu_mix[15:0], fu_mix[31:16]};
      2'd3: fu_rot = {fu_mix[7:0],  fu_mix[31:8]};
    endcase
    fu_rd = fu_valid ? (fu_rs1 ^ fu_rot) : '0;
  end

  always_comb begin
    st_d    = st_q;
    step_d  = step_q;
    acc_d   = acc_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    out_d   = out_q;
    dec_d   = dec_q;
    last_d  = last_q;
    unique case (st_q)
      StIdle: if (accept) st_d = StRun;
      StRun: begin
        acc_d  = fu_rd;
        if (bs == 2'd3) out_d[{col, 5'b0} +: 32] = fu_rd;
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) st_d = StDone;
      end
      StDone: if (rsp_ready) st_d = accept ? StRun : StIdle;
      default: st_d = StIdle;
    endcase
    if (accept) begin
      state_d = req_state;
      rkey_d  = req_rkey;
      dec_d   = SaesDecEn & req_dec;
      last_d  = req_last;
      step_d  = '0;
    end
    if (flush) begin
      st_d   = StIdle;
      step_d = '0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      st_q    <= StIdle;
      step_q  <= '0;
      acc_q   <= '0;
      state_q <= '0;
      rkey_q  <= '0;
      out_q   <= '0;
      dec_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      out_q   <= out_d;
      dec_q   <= dec_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_riscv_crypto_aes32_round_seq.sv
// Self-checking bench for riscv_crypto_aes32_round_seq against a byte-array AES round model.
module tb_riscv_crypto_aes32_round_seq;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_dec = 1'b0;
  logic         req_last = 1'b0;
  logic [127:0] req_state = '0;
  logic [127:0] req_rkey = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_state;

  int n_checks = 0;
  int n_fails  = 0;

  riscv_crypto_aes32_round_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_last  (req_last),
    .req_state (req_state),
    .req_rkey  (req_rkey),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_state (rsp_state)
  );

  always #5 g_clk = ~g_clk;

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] sbox_t [256];
  logic [7:0] inv_sbox_t [256];

  // FIPS-197 hex strings list byte 0 first; the port packs byte 0 at the low end.
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input int b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) == 1) p = p ^ x;
      x = (x[7] == 1'b1) ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic d, input logic l);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[8*i +: 8];
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        if (!d) t[4*c+w] = sbox_t[b[4*((c+w)%4)+w]];
        else    t[4*c+w] = inv_sbox_t[b[4*((c-w+4)%4)+w]];
      end
    end
    if (!l) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (!d) begin
          t[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          t[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end else begin
          t[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
          t[4*c+1] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
          t[4*c+2] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
          t[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
        end
      end
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = t[i] ^ k[8*i +: 8];
    return r;
  endfunction

  function automatic logic eff_dec(input logic d);
`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
    return d;
`else
    return 1'b0 & d;
`endif
  endfunction

  logic [127:0] v2_s, v2_k, v2_o, v3_s, v3_k, v3_o;

  task automatic scramble_req();
    req_state = {$urandom, $urandom, $urandom, $urandom};
    req_rkey  = {$urandom, $urandom, $urandom, $urandom};
    req_dec   = 1'($urandom);
    req_last  = 1'($urandom);
  endtask

  // Presents one request for a single edge; caller ensures req_ready is high.
  task automatic issue(input logic [127:0] s, input logic [127:0] k, input logic d, input logic l);
    req_state = s; req_rkey = k; req_dec = d; req_last = l; req_valid = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    scramble_req();
  endtask

  // Counts edges until rsp_valid, toggling ignored garbage on the request side meanwhile.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      req_valid = (lat < 10) ? 1'($urandom) : 1'b0;
      scramble_req();
      @(posedge g_clk); #1;
      lat++;
    end
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bit seen;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_state !== '0) begin
      n_fails++;
      $display("FAIL reset_state: got valid=%b ready=%b state=%h, want 0 1 0",
               rsp_valid, req_ready, rsp_state);
    end
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    @(posedge g_clk); #1;
    issue(v2_s, v2_k, 1'b0, 1'b0);
    repeat (7) @(posedge g_clk);
    #1 g_resetn = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_state !== '0) begin
      n_fails++;
      $display("FAIL reset_mid_run: got valid=%b ready=%b state=%h, want 0 1 0",
               rsp_valid, req_ready, rsp_state);
    end
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge g_clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fails++;
      $display("FAIL reset_no_partial_rsp: got rsp_valid=1, want 0");
    end
    lat = 0;
  endtask

  task automatic test_fips_round();
    int lat;
    issue(v2_s, v2_k, 1'b0, 1'b0);
    wait_rsp(lat);
    n_checks++;
    if (lat != 16) begin
      n_fails++;
      $display("FAIL fips_latency: got %0d edges, want 16", lat);
    end
    n_checks++;
    if (rsp_state !== v2_o) begin
      n_fails++;
      $display("FAIL fips_round1: got %h want %h", rsp_state, v2_o);
    end
    consume();
  endtask

  task automatic test_final_round();
    int lat;
    issue(v3_s, v3_k, 1'b0, 1'b1);
    wait_rsp(lat);
    n_checks++;
    if (lat != 16 || rsp_state !== v3_o) begin
      n_fails++;
      $display("FAIL final_round: got lat=%0d %h want lat=16 %h", lat, rsp_state, v3_o);
    end
    consume();
  endtask

  task automatic test_dec_round();
    int lat;
    logic [127:0] s, exp;
    s = v3_o ^ v3_k;
`ifdef RISCV_CRYPTO_AES32_ROUND_SEQ_DEC_EN
    exp = v3_s;
`else
    exp = ref_round(s, '0, 1'b0, 1'b1);
`endif
    issue(s, '0, 1'b1, 1'b1);
    wait_rsp(lat);
    n_checks++;
    if (lat != 16 || rsp_state !== exp) begin
      n_fails++;
      $display("FAIL dec_round: got lat=%0d %h want lat=16 %h", lat, rsp_state, exp);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bad;
    issue(v2_s, v2_k, 1'b0, 1'b0);
    wait_rsp(lat);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk); #1;
      if (rsp_state !== v2_o || req_ready !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL backpressure_hold: got %h ready=%b valid=%b want %h 0 1",
               rsp_state, req_ready, rsp_valid, v2_o);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_state = v3_s; req_rkey = v3_k; req_dec = 1'b0; req_last = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_ready: got %b want 1", req_ready);
    end
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    scramble_req();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_rsp_drop: got %b want 0", rsp_valid);
    end
    wait_rsp(lat);
    n_checks++;
    if (lat != 16 || rsp_state !== v3_o) begin
      n_fails++;
      $display("FAIL b2b_second: got lat=%0d %h want lat=16 %h", lat, rsp_state, v3_o);
    end
    consume();
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    issue({$urandom, $urandom, $urandom, $urandom}, v2_k, 1'b0, 1'b0);
    repeat (9) @(posedge g_clk);
    #1 flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL flush_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge g_clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fails++;
      $display("FAIL flush_no_rsp: got rsp_valid=1 want 0");
    end
    // Flush in DONE beats a simultaneous rsp handshake and new accept.
    issue(v3_s, v3_k, 1'b0, 1'b1);
    wait_rsp(lat);
    rsp_ready = 1'b1; req_valid = 1'b1; flush = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid || !req_ready) seen = 1'b1;
      @(posedge g_clk); #1;
    end
    n_checks++;
    if (seen) begin
      n_fails++;
      $display("FAIL flush_beats_accept: got a run after flush, want idle");
    end
    issue(v2_s, v2_k, 1'b0, 1'b0);
    wait_rsp(lat);
    n_checks++;
    if (lat != 16 || rsp_state !== v2_o) begin
      n_fails++;
      $display("FAIL flush_recover: got lat=%0d %h want lat=16 %h", lat, rsp_state, v2_o);
    end
    consume();
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] s, k, exp;
    logic d, l;
    for (int n = 0; n < 24; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      d = 1'($urandom);
      l = 1'($urandom);
      exp = ref_round(s, k, eff_dec(d), l);
      issue(s, k, d, l);
      wait_rsp(lat);
      repeat ($urandom_range(0, 3)) @(posedge g_clk);
      #1;
      n_checks++;
      if (lat != 16 || rsp_state !== exp) begin
        n_fails++;
        $display("FAIL random_round[%0d] dec=%b last=%b: got lat=%0d %h want lat=16 %h",
                 n, d, l, lat, rsp_state, exp);
      end
      consume();
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < 16; j++) sbox_t[16*r+j] = sbox_rows[r][127-8*j -: 8];
    end
    for (int i = 0; i < 256; i++) inv_sbox_t[sbox_t[i]] = 8'(i);
    v2_s = fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    v2_k = fips(128'ha0fafe1788542cb123a339392a6c7605);
    v2_o = fips(128'ha49c7ff2689f352b6b5bea43026a5049);
    v3_s = fips(128'heb40f21e592e38848ba113e71bc342d2);
    v3_k = fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    v3_o = fips(128'h3925841d02dc09fbdc118597196a0b32);

    test_reset();
    test_fips_round();
    test_final_round();
    test_dec_round();
    test_back_to_back();
    test_flush();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
